// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command sequencer.
package alu_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_OP_W   = 3;
    localparam int unsigned FLAGS_W    = 4;
    localparam int unsigned CNT_W      = 4;

    // Bit positions inside the {overflow,zero,neg,carry} flag word
    localparam int unsigned FLG_OVF   = 3;
    localparam int unsigned FLG_ZERO  = 2;
    localparam int unsigned FLG_NEG   = 1;
    localparam int unsigned FLG_CARRY = 0;

    typedef enum logic [DEF_OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_XOR = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_NOR = 3'd4,
        OP_SL  = 3'd5,
        OP_SR  = 3'd6,
        OP_SUB = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_sequencer.sv
// Issues one command at a time to a combinational ALU, waits SETTLE_CYCLES, returns result/flags.
// Optional sticky {overflow,carry} status enabled by defining ALU_SEQ_STICKY_STATUS_EN.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W        = DEF_DATA_W,
    parameter int unsigned OP_W          = DEF_OP_W,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic [OP_W-1:0]   alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_flags,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [3:0]        rsp_flags,
    output logic              busy,
    input  logic              clr_status,
    output logic [1:0]        status_flags
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_settle_range_check
        $error("alu_sequencer: SETTLE_CYCLES must be within 1..15");
    end

    seq_state_e       state;
    seq_state_e       state_nx;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             capture;

    assign cmd_ready = (state == ST_IDLE);

    // State register; rsp_valid/busy are registered decodes of the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            rsp_valid <= (state_nx == ST_RESP);
            busy      <= (state_nx != ST_IDLE);
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        capture  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept   = 1'b1;
                    state_nx = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (cnt == '0) begin
                    capture  = 1'b1;
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Settle counter: loaded on accept so capture lands exactly SETTLE_CYCLES edges later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CNT_W'(SETTLE_CYCLES - 1);
        end else if (state == ST_DRIVE && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // ALU operand registers only move on an accepted command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
        end else if (accept) begin
            alu_opcode <= cmd_op;
            alu_a      <= cmd_a;
            alu_b      <= cmd_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else if (capture) begin
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
        end
    end

`ifdef ALU_SEQ_STICKY_STATUS_EN
    logic [1:0] sticky;

    // Set on capture takes priority over a same-edge clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky <= '0;
        end else begin
            if (clr_status) begin
                sticky <= '0;
            end
            if (capture && alu_flags[FLG_OVF]) begin
                sticky[1] <= 1'b1;
            end
            if (capture && alu_flags[FLG_CARRY]) begin
                sticky[0] <= 1'b1;
            end
        end
    end

    assign status_flags = sticky;
`else
    logic unused_clr_status;

    assign unused_clr_status = clr_status;
    assign status_flags      = '0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU attached to its alu_* ports.
// Define ALU_SEQ_STICKY_STATUS_EN to exercise the sticky status path.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned S  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = '0;
    logic [DW-1:0] cmd_a = '0;
    logic [DW-1:0] cmd_b = '0;
    logic [2:0]    alu_opcode;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_result;
    logic [3:0]    alu_flags;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_result;
    logic [3:0]    rsp_flags;
    logic          busy;
    logic          clr_status = 1'b0;
    logic [1:0]    status_flags;

    typedef struct {
        logic [DW-1:0] res;
        logic [3:0]    flg;
        int unsigned   acc;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    int unsigned cyc = 0;
    int unsigned last_acc = 0;
    logic        prev_rv = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_sequencer #(
        .DATA_W        (DW),
        .OP_W          (3),
        .SETTLE_CYCLES (S)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .alu_opcode   (alu_opcode),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .alu_flags    (alu_flags),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags),
        .busy         (busy),
        .clr_status   (clr_status),
        .status_flags (status_flags)
    );

    // Reference ALU: returns {overflow,zero,neg,carry,result}
    function automatic logic [35:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic        c;
        logic        v;
        s = '0;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (alu_op_e'(op))
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
            end
            OP_XOR: r = a ^ b;
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_NOR: r = ~(a | b);
            OP_SL:  r = a << b[4:0];
            OP_SR:  r = a >> b[4:0];
            OP_SUB: begin
                r = a - b;
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            default: r = '0;
        endcase
        return {v, (r == 32'd0), r[31], c, r};
    endfunction

    logic [35:0] alu_model;
    always_comb alu_model = alu_ref(alu_opcode, alu_a, alu_b);
    assign alu_result = alu_model[31:0];
    assign alu_flags  = alu_model[35:32];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Response monitor, sampled well after the falling edge
    always @(negedge clk) begin
        #2;
        if (rst_n && rsp_valid && !prev_rv) begin
            if (sb.size() == 0) check("unexpected_rsp", 64'(rsp_valid), 64'd0);
            else                check("latency", 64'(cyc - sb[0].acc), 64'(S));
        end
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("sb_empty", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_result", 64'(rsp_result), 64'(e.res));
                check("rsp_flags", 64'(rsp_flags), 64'(e.flg));
            end
        end
        prev_rv = rsp_valid;
    end

    // Called at a falling edge; returns at the falling edge after the accept edge
    task automatic send(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] er, input logic [3:0] ef);
        int   n;
        exp_t e;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", 64'd0, 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        e.res = er;
        e.flg = ef;
        e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
        last_acc  = cyc;
        check("alu_a_drive", 64'(alu_a), 64'(a));
        check("alu_op_drive", 64'(alu_opcode), 64'(op));
    endtask

    task automatic send_ref(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [35:0] r;
        r = alu_ref(op, a, b);
        send(op, a, b, r[31:0], r[35:32]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] hold_res;
        logic [3:0]    hold_flg;
        logic [DW-1:0] hold_a;
        int unsigned   prev_acc;
        int            n;

        repeat (3) @(negedge clk);
        check("rst_alu_a", 64'(alu_a), 64'd0);
        check("rst_alu_op", 64'(alu_opcode), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_result", 64'(rsp_result), 64'd0);
        check("rst_rsp_flags", 64'(rsp_flags), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_status", 64'(status_flags), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // Directed arithmetic corners with hand-computed expectations
        rsp_ready = 1'b1;
        send(OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b0010);
        check("busy_in_drive", 64'(busy), 64'd1);
        check("cmd_ready_in_drive", 64'(cmd_ready), 64'd0);
        send(OP_SUB, 32'd5, 32'd5, 32'd0, 4'b0100);
        send(OP_SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 4'b1000);
        send(OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b0101);
        drain();
`ifndef ALU_SEQ_STICKY_STATUS_EN
        check("status_tied_zero", 64'(status_flags), 64'd0);
`endif

        // Back-pressure: response held, new commands ignored
        rsp_ready = 1'b0;
        send_ref(OP_OR, 32'h1234_0000, 32'h0000_5678);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("stall_rsp_wait", 64'(rsp_valid), 64'd1);
        hold_res = rsp_result;
        hold_flg = rsp_flags;
        hold_a   = alu_a;
        repeat (5) begin
            cmd_valid = 1'b1;
            cmd_op    = 3'd7;
            cmd_a     = $urandom;
            cmd_b     = $urandom;
            @(negedge clk);
            check("stall_valid", 64'(rsp_valid), 64'd1);
            check("stall_result", 64'(rsp_result), 64'(hold_res));
            check("stall_flags", 64'(rsp_flags), 64'(hold_flg));
            check("stall_cmd_ready", 64'(cmd_ready), 64'd0);
            check("stall_alu_a", 64'(alu_a), 64'(hold_a));
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();
        @(negedge clk);
        check("stall_release_idle", 64'(busy), 64'd0);

        // Reset while an operation is in DRIVE
        send_ref(OP_ADD, 32'd100, 32'd23);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_alu_a", 64'(alu_a), 64'd0);
        check("midrst_alu_op", 64'(alu_opcode), 64'd0);
        check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (S + 3) begin
            @(negedge clk);
            check("midrst_no_rsp", 64'(rsp_valid), 64'd0);
        end
        send_ref(OP_ADD, 32'd100, 32'd23);
        drain();

        // Back-to-back, every opcode, one accept per S+2 cycles
        prev_acc = 0;
        for (int i = 0; i < 8; i++) begin
            send_ref(3'(i), $urandom, $urandom);
            if (i > 0) check("b2b_spacing", 64'(last_acc - prev_acc), 64'(S + 2));
            prev_acc = last_acc;
        end
        drain();

`ifdef ALU_SEQ_STICKY_STATUS_EN
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        check("sticky_clr_init", 64'(status_flags), 64'd0);
        send(OP_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b0011);
        drain();
        check("sticky_carry", 64'(status_flags), 64'b01);
        send(OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b0101);
        repeat (S - 1) @(negedge clk);
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        check("sticky_set_wins", 64'(status_flags), 64'b01);
        drain();
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        check("sticky_clr", 64'(status_flags), 64'b00);
        send(OP_SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 4'b1000);
        drain();
        check("sticky_ovf", 64'(status_flags), 64'b10);
`else
        clr_status = 1'b1;
        send(OP_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b0011);
        clr_status = 1'b0;
        drain();
        check("status_off_carry", 64'(status_flags), 64'd0);
`endif

        @(negedge clk);
        check("end_idle_busy", 64'(busy), 64'd0);
        check("end_cmd_ready", 64'(cmd_ready), 64'd1);
        check("end_sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
